// File: rtl/md_pkg.sv
// Shared encodings for the multiply/divide unit: operation codes, FSM states,
// iteration count and sign-correction helpers.
package md_pkg;

    localparam int MD_NB_REG = 32;

    localparam logic [2:0] MD_MULT  = 3'b000;
    localparam logic [2:0] MD_MULTU = 3'b001;
    localparam logic [2:0] MD_DIV   = 3'b010;
    localparam logic [2:0] MD_DIVU  = 3'b011;
    localparam logic [2:0] MD_MTHI  = 3'b100;
    localparam logic [2:0] MD_MTLO  = 3'b101;

    localparam logic [1:0] MD_ST_IDLE = 2'd0;
    localparam logic [1:0] MD_ST_CALC = 2'd1;
    localparam logic [1:0] MD_ST_SIGN = 2'd2;
    localparam logic [1:0] MD_ST_DONE = 2'd3;

    localparam logic [5:0] MD_ITER_CNT = 6'd32;

    function automatic logic [MD_NB_REG-1:0] f_cond_neg32(input logic [MD_NB_REG-1:0] value,
                                                          input logic neg);
        return neg ? (~value + 32'd1) : value;
    endfunction

    function automatic logic [2*MD_NB_REG-1:0] f_cond_neg64(input logic [2*MD_NB_REG-1:0] value,
                                                            input logic neg);
        return neg ? (~value + 64'd1) : value;
    endfunction

endpackage

// File: rtl/md_iter_core.sv
// One combinational iteration step: shift-add multiply or restoring divide.
// The divide path is only built when MD_DIV_EN is defined.
module md_iter_core #(
    parameter int NB_REG = 32
) (
    input  logic [2*NB_REG-1:0] i_acc,
    input  logic [NB_REG-1:0]   i_opnd,
    input  logic                i_is_div,
    output logic [2*NB_REG-1:0] o_acc
);

    logic [NB_REG:0]     mul_sum_s;
    logic [2*NB_REG-1:0] mul_next_s;

    // Multiply: add the multiplicand into the upper half when the multiplier LSB is set, then shift right
    always_comb begin
        mul_sum_s  = {1'b0, i_acc[2*NB_REG-1:NB_REG]};
        if (i_acc[0]) begin
            mul_sum_s = {1'b0, i_acc[2*NB_REG-1:NB_REG]} + {1'b0, i_opnd};
        end else begin
            mul_sum_s = {1'b0, i_acc[2*NB_REG-1:NB_REG]};
        end
        mul_next_s = {mul_sum_s, i_acc[NB_REG-1:1]};
    end

`ifdef MD_DIV_EN
    logic [NB_REG:0]   rem_sh_s;
    logic [NB_REG:0]   trial_s;
    logic [NB_REG-1:0] rem_next_s;
    logic              q_bit_s;

    // Divide: shift the next dividend bit into the remainder and keep the subtraction if it did not borrow
    always_comb begin
        rem_sh_s = i_acc[2*NB_REG-1:NB_REG-1];
        trial_s  = rem_sh_s - {1'b0, i_opnd};
        if (!trial_s[NB_REG]) begin
            rem_next_s = trial_s[NB_REG-1:0];
            q_bit_s    = 1'b1;
        end else begin
            rem_next_s = rem_sh_s[NB_REG-1:0];
            q_bit_s    = 1'b0;
        end
    end

    // Select the step matching the operation in flight
    always_comb begin
        if (i_is_div) begin
            o_acc = {rem_next_s, i_acc[NB_REG-2:0], q_bit_s};
        end else begin
            o_acc = mul_next_s;
        end
    end
`else
    // Without a divider the accumulator simply holds for a divide
    always_comb begin
        if (i_is_div) begin
            o_acc = i_acc;
        end else begin
            o_acc = mul_next_s;
        end
    end
`endif

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit holding the HI/LO registers (MTHI/MTLO writes).
// Define MD_DIV_EN to build the divider; otherwise DIV/DIVU complete at once with HI/LO unchanged.
module mult_div_unit
    import md_pkg::*;
#(
    parameter int NB_REG   = 32,
    parameter int NB_MD_OP = 3
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_start,
    input  logic [NB_MD_OP-1:0] i_md_op,
    input  logic [NB_REG-1:0]   i_a,
    input  logic [NB_REG-1:0]   i_b,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_div_by_zero,
    output logic [NB_REG-1:0]   o_hi,
    output logic [NB_REG-1:0]   o_lo
);

    logic [1:0]          state_r;
    logic [5:0]          cnt_r;
    logic [2*NB_REG-1:0] acc_r;
    logic [NB_REG-1:0]   opnd_r;
    logic                is_div_r;
    logic                neg_lo_r;
    logic                neg_hi_r;
    logic                dbz_r;
    logic [NB_REG-1:0]   hi_r;
    logic [NB_REG-1:0]   lo_r;
    logic                busy_r;
    logic                done_r;
    logic                dbz_out_r;

    logic                is_mul_op_s;
    logic                is_div_op_s;
    logic                is_signed_s;
    logic                a_neg_s;
    logic                b_neg_s;
    logic [NB_REG-1:0]   a_mag_s;
    logic [NB_REG-1:0]   b_mag_s;
    logic [2*NB_REG-1:0] acc_next_s;
    logic [2*NB_REG-1:0] prod_s;
    logic [NB_REG-1:0]   res_hi_s;
    logic [NB_REG-1:0]   res_lo_s;

    // Decode the requested operation and form operand magnitudes
    always_comb begin
        is_mul_op_s = 1'b0;
        is_div_op_s = 1'b0;
        is_signed_s = 1'b0;
        case (i_md_op)
            MD_MULT:  begin is_mul_op_s = 1'b1; is_signed_s = 1'b1; end
            MD_MULTU: begin is_mul_op_s = 1'b1; end
            MD_DIV:   begin is_div_op_s = 1'b1; is_signed_s = 1'b1; end
            MD_DIVU:  begin is_div_op_s = 1'b1; end
            default:  begin is_mul_op_s = 1'b0; end
        endcase
        a_neg_s = is_signed_s & i_a[NB_REG-1];
        b_neg_s = is_signed_s & i_b[NB_REG-1];
        a_mag_s = f_cond_neg32(i_a, a_neg_s);
        b_mag_s = f_cond_neg32(i_b, b_neg_s);
    end

    md_iter_core #(
        .NB_REG (NB_REG)
    ) u_iter_core (
        .i_acc    (acc_r),
        .i_opnd   (opnd_r),
        .i_is_div (is_div_r),
        .o_acc    (acc_next_s)
    );

    // Sign-correct the finished magnitudes; divide by zero forces an all-ones quotient
    always_comb begin
        prod_s = f_cond_neg64(acc_r, neg_lo_r);
        if (is_div_r) begin
            res_hi_s = f_cond_neg32(acc_r[2*NB_REG-1:NB_REG], neg_hi_r);
            if (dbz_r) begin
                res_lo_s = {NB_REG{1'b1}};
            end else begin
                res_lo_s = f_cond_neg32(acc_r[NB_REG-1:0], neg_lo_r);
            end
        end else begin
            res_hi_s = prod_s[2*NB_REG-1:NB_REG];
            res_lo_s = prod_s[NB_REG-1:0];
        end
    end

    // FSM, iteration counter, datapath registers and HI/LO
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_r   <= MD_ST_IDLE;
            cnt_r     <= 6'd0;
            acc_r     <= {(2*NB_REG){1'b0}};
            opnd_r    <= {NB_REG{1'b0}};
            is_div_r  <= 1'b0;
            neg_lo_r  <= 1'b0;
            neg_hi_r  <= 1'b0;
            dbz_r     <= 1'b0;
            hi_r      <= {NB_REG{1'b0}};
            lo_r      <= {NB_REG{1'b0}};
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            dbz_out_r <= 1'b0;
        end else begin
            done_r    <= 1'b0;
            dbz_out_r <= 1'b0;
            case (state_r)
                // DONE is not busy, so it accepts a new request exactly like IDLE
                MD_ST_IDLE, MD_ST_DONE: begin
                    state_r <= MD_ST_IDLE;
                    if (i_start) begin
                        if (is_mul_op_s) begin
                            state_r  <= MD_ST_CALC;
                            busy_r   <= 1'b1;
                            cnt_r    <= 6'd0;
                            acc_r    <= {{NB_REG{1'b0}}, b_mag_s};
                            opnd_r   <= a_mag_s;
                            is_div_r <= 1'b0;
                            neg_lo_r <= a_neg_s ^ b_neg_s;
                            neg_hi_r <= 1'b0;
                            dbz_r    <= 1'b0;
                        end else if (is_div_op_s) begin
`ifdef MD_DIV_EN
                            state_r  <= MD_ST_CALC;
                            busy_r   <= 1'b1;
                            cnt_r    <= 6'd0;
                            acc_r    <= {{NB_REG{1'b0}}, a_mag_s};
                            opnd_r   <= b_mag_s;
                            is_div_r <= 1'b1;
                            neg_lo_r <= a_neg_s ^ b_neg_s;
                            neg_hi_r <= a_neg_s;
                            dbz_r    <= (i_b == {NB_REG{1'b0}});
`else
                            state_r  <= MD_ST_DONE;
                            done_r   <= 1'b1;
`endif
                        end else if (i_md_op == MD_MTHI) begin
                            hi_r <= i_a;
                        end else if (i_md_op == MD_MTLO) begin
                            lo_r <= i_a;
                        end
                    end
                end
                // 32 steps, then one further CALC cycle before SIGN keeps the 34-cycle latency
                MD_ST_CALC: begin
                    if (cnt_r == MD_ITER_CNT) begin
                        state_r <= MD_ST_SIGN;
                    end else begin
                        acc_r <= acc_next_s;
                        cnt_r <= cnt_r + 6'd1;
                    end
                end
                MD_ST_SIGN: begin
                    hi_r      <= res_hi_s;
                    lo_r      <= res_lo_s;
                    done_r    <= 1'b1;
                    dbz_out_r <= is_div_r & dbz_r;
                    busy_r    <= 1'b0;
                    state_r   <= MD_ST_DONE;
                end
                default: begin
                    state_r <= MD_ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy        = busy_r;
    assign o_done        = done_r;
    assign o_div_by_zero = dbz_out_r;
    assign o_hi          = hi_r;
    assign o_lo          = lo_r;

endmodule
